// File: rtl/burst_ram_pkg.sv
// Shared constants, state encoding and small helpers for the burst RAM slice.
package burst_ram_pkg;

    localparam int DATA_W                   = 64;
    localparam int MASK_W                   = 8;
    localparam int BURST_BEATS              = 4;
    localparam int BEAT_W                   = $clog2(BURST_BEATS);
    localparam int LAT_W                    = 4;

    localparam int DEFAULT_DEPTH_BITWIDTH   = 12;
    localparam int DEFAULT_READ_LATENCY     = 8;
    localparam int DEFAULT_COMMAND_INTERVAL = 14;
    localparam int DEFAULT_INIT_CYCLES      = 16;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE,
        ST_READ_WAIT,
        ST_READ_BURST,
        ST_RECOVER
    } state_e;

    function automatic logic is_last_beat(input logic [BEAT_W-1:0] beat);
        return beat == BEAT_W'(BURST_BEATS - 1);
    endfunction

endpackage

// File: rtl/burst_ram_array.sv
// Simple dual-port word store: one synchronous write port, one registered read port.
module burst_ram_array
    import burst_ram_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_DEPTH_BITWIDTH,
    parameter int WORD_W = DATA_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];
    logic [WORD_W-1:0] rd_data_q;

    // NOTE: the storage array has no reset so it maps onto block RAM and keeps its contents across rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/burst_ram.sv
// Fixed 4-beat burst memory with calibration delay, fixed read latency and a
// minimum command spacing enforced through busy.
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int DEPTH_BITWIDTH   = DEFAULT_DEPTH_BITWIDTH,
    parameter int READ_LATENCY     = DEFAULT_READ_LATENCY,
    parameter int COMMAND_INTERVAL = DEFAULT_COMMAND_INTERVAL,
    parameter int INIT_CYCLES      = DEFAULT_INIT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      br_cmd,
    input  logic                      br_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] br_addr,
    input  logic [DATA_W-1:0]         br_wr_data,
    input  logic [MASK_W-1:0]         br_data_mask,
    output logic [DATA_W-1:0]         br_rd_data,
    output logic                      br_rd_data_valid,
    output logic                      busy,
    output logic                      init_calib,
    output logic                      cmd_overrun
);

    localparam int CNT_W  = $clog2(COMMAND_INTERVAL + 1);
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);

    state_e                    state_q, state_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [LAT_W-1:0]          lat_q, lat_d;
    logic [DEPTH_BITWIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [INIT_W-1:0]         init_cnt_q, init_cnt_d;
    logic                      init_calib_q, init_calib_d;
    logic                      overrun_q, overrun_d;
    logic                      rd_valid_q, rd_valid_d;

    logic                      accept;
    logic                      ram_we, ram_re;
    logic [DEPTH_BITWIDTH-1:0] ram_waddr, ram_raddr, beat_addr;
    logic [DATA_W-1:0]         ram_rdata;

    // Every byte is always written, so the mask has no consumer.
    logic unused_mask;
    assign unused_mask = ^br_data_mask;

    assign busy      = !init_calib_q || (cnt_q != '0);
    assign accept    = br_cmd_en && !busy;
    assign beat_addr = addr_q + DEPTH_BITWIDTH'(beat_q);

    // NOTE: every signal gets a default before the case so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        lat_d        = lat_q;
        addr_d       = addr_q;
        cnt_d        = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        init_cnt_d   = init_cnt_q;
        init_calib_d = init_calib_q;
        overrun_d    = overrun_q || (br_cmd_en && busy);
        ram_we       = 1'b0;
        ram_waddr    = beat_addr;
        ram_re       = 1'b0;
        ram_raddr    = beat_addr;

        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
                    init_calib_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end

            // The counter can drain before RECOVER is left, so both states accept.
            ST_IDLE, ST_RECOVER: begin
                if (accept) begin
                    addr_d = br_addr;
                    lat_d  = LAT_W'(1);
                    cnt_d  = CNT_W'(COMMAND_INTERVAL - 1);
                    if (br_cmd) begin
                        ram_we    = 1'b1;
                        ram_waddr = br_addr;
                        beat_d    = BEAT_W'(1);
                        state_d   = ST_WRITE;
                    end else begin
                        beat_d  = '0;
                        state_d = ST_READ_WAIT;
                    end
                end else if (state_q == ST_RECOVER && cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end

            ST_WRITE: begin
                ram_we = 1'b1;
                beat_d = beat_q + BEAT_W'(1);
                if (is_last_beat(beat_q)) begin
                    state_d = ST_RECOVER;
                end
            end

            // lat_q is the index of the upcoming edge relative to the accept edge.
            ST_READ_WAIT: begin
                if (lat_q == LAT_W'(READ_LATENCY)) begin
                    ram_re  = 1'b1;
                    beat_d  = beat_q + BEAT_W'(1);
                    state_d = ST_READ_BURST;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end

            ST_READ_BURST: begin
                ram_re = 1'b1;
                beat_d = beat_q + BEAT_W'(1);
                if (is_last_beat(beat_q)) begin
                    state_d = ST_RECOVER;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase

        // A burst interrupted by reset must not touch the array on the reset edge.
        if (rst) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end

        rd_valid_d = ram_re;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            beat_q       <= '0;
            lat_q        <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            init_cnt_q   <= '0;
            init_calib_q <= 1'b0;
            overrun_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            lat_q        <= lat_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            init_cnt_q   <= init_cnt_d;
            init_calib_q <= init_calib_d;
            overrun_q    <= overrun_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    burst_ram_array #(
        .ADDR_W (DEPTH_BITWIDTH),
        .WORD_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (br_wr_data),
        .rd_en   (ram_re),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    assign br_rd_data       = rd_valid_q ? ram_rdata : '0;
    assign br_rd_data_valid = rd_valid_q;
    assign init_calib       = init_calib_q;
    assign cmd_overrun      = overrun_q;

endmodule

// File: tb/tb_burst_ram.sv
// Scoreboard bench for burst_ram: reads push expected beats with their due cycle,
// a negedge monitor pops and compares them as the DUT presents data.
module tb_burst_ram;
    import burst_ram_pkg::*;

    localparam int AW = 12;
    localparam int L  = 8;
    localparam int CI = 14;
    localparam int IC = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          br_cmd = 1'b0;
    logic          br_cmd_en = 1'b0;
    logic [AW-1:0] br_addr = '0;
    logic [63:0]   br_wr_data = '0;
    logic [7:0]    br_data_mask = '0;
    logic [63:0]   br_rd_data;
    logic          br_rd_data_valid;
    logic          busy;
    logic          init_calib;
    logic          cmd_overrun;

    burst_ram #(
        .DEPTH_BITWIDTH   (AW),
        .READ_LATENCY     (L),
        .COMMAND_INTERVAL (CI),
        .INIT_CYCLES      (IC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_wr_data       (br_wr_data),
        .br_data_mask     (br_data_mask),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid),
        .busy             (busy),
        .init_calib       (init_calib),
        .cmd_overrun      (cmd_overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] data;
        int unsigned cyc;
        bit          known;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [63:0] model   [0:(1<<AW)-1];
    bit          known_m [0:(1<<AW)-1];
    bit          mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_not_busy();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) check("busy_timeout", 64'(busy), 64'(0));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!init_calib && n < 100) begin
            tick();
            n++;
        end
        check("calib_reached", 64'(init_calib), 64'(1));
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("sb_drained", 64'(sb_q.size()), 64'(0));
    endtask

    task automatic write_burst(input logic [AW-1:0] addr, input logic [63:0] d0, input logic [63:0] d1,
                               input logic [63:0] d2, input logic [63:0] d3, input logic [7:0] mask,
                               output int unsigned acc_cyc);
        logic [63:0]   d [4];
        logic [AW-1:0] a;
        d = '{d0, d1, d2, d3};
        wait_not_busy();
        br_cmd       = 1'b1;
        br_addr      = addr;
        br_data_mask = mask;
        br_wr_data   = d[0];
        br_cmd_en    = 1'b1;
        tick();
        acc_cyc   = cyc;
        br_cmd_en = 1'b0;
        for (int k = 1; k < 4; k++) begin
            br_wr_data = d[k];
            tick();
        end
        br_wr_data   = {$urandom, $urandom};
        br_data_mask = '0;
        for (int k = 0; k < 4; k++) begin
            a          = addr + AW'(k);
            model[a]   = d[k];
            known_m[a] = 1'b1;
        end
    endtask

    task automatic read_burst(input logic [AW-1:0] addr, output int unsigned acc_cyc);
        logic [AW-1:0] a;
        exp_t          e;
        wait_not_busy();
        br_cmd    = 1'b0;
        br_addr   = addr;
        br_cmd_en = 1'b1;
        tick();
        acc_cyc   = cyc;
        br_cmd_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a       = addr + AW'(k);
            e.data  = model[a];
            e.cyc   = acc_cyc + L + k;
            e.known = known_m[a];
            sb_q.push_back(e);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"},   64'(br_rd_data_valid), 64'(0));
        check({tag, "_data"},    br_rd_data,            64'h0);
        check({tag, "_calib"},   64'(init_calib),       64'(0));
        check({tag, "_busy"},    64'(busy),             64'(1));
        check({tag, "_overrun"}, 64'(cmd_overrun),      64'(0));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (br_rd_data_valid) begin
                if (sb_q.size() == 0) begin
                    check("rd_unexpected_beat", 64'(1), 64'(0));
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rd_beat_cycle", 64'(cyc), 64'(mon_e.cyc));
                    if (mon_e.known) check("rd_beat_data", br_rd_data, mon_e.data);
                end
            end else begin
                check("rd_idle_zero", br_rd_data, 64'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned   wacc, racc, racc2;
        logic [AW-1:0] ra;
        logic [63:0]   rd0, rd1, rd2, rd3;

        // Reset, then calibration timing and a too-early command.
        rst = 1'b1;
        tick();
        tick();
        mon_en = 1'b1;
        check_reset_state("por");
        rst = 1'b0;
        for (int k = 1; k <= IC; k++) begin
            br_cmd_en = (k == 3);
            br_cmd    = 1'b0;
            tick();
            check("calib_ramp", 64'(init_calib), 64'(k == IC));
            check("busy_ramp",  64'(busy),       64'(k != IC));
        end
        br_cmd_en = 1'b0;
        check("early_cmd_overrun", 64'(cmd_overrun), 64'(1));
        check("early_cmd_no_beats", 64'(sb_q.size()), 64'(0));

        rst = 1'b1;
        tick();
        tick();
        check_reset_state("rst2");
        rst = 1'b0;
        wait_ready();

        // Write then read back exactly one command interval later.
        write_burst(12'h004, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}, 8'h00, wacc);
        repeat (CI - 5) tick();
        check("busy_before_interval", 64'(busy), 64'(1));
        tick();
        check("busy_at_interval", 64'(busy), 64'(0));
        read_burst(12'h004, racc);
        check("read_accept_cycle", 64'(racc), 64'(wacc + CI));
        drain();

        // Address wrap at the top of the array.
        write_burst(12'hFFE, 64'd1, 64'd2, 64'd3, 64'd4, 8'h00, wacc);
        read_burst(12'hFFE, racc);
        drain();
        read_burst(12'h000, racc);
        drain();

        // Mask is ignored; every byte lands.
        write_burst(12'h100, 64'hDEADBEEF_CAFEF00D, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000,
                    64'h5A5A_A5A5_5A5A_A5A5, 8'hFF, wacc);
        read_burst(12'h100, racc);
        drain();

        // A handful of random bursts.
        for (int i = 0; i < 6; i++) begin
            ra  = AW'($urandom);
            rd0 = {$urandom, $urandom};
            rd1 = {$urandom, $urandom};
            rd2 = {$urandom, $urandom};
            rd3 = {$urandom, $urandom};
            write_burst(ra, rd0, rd1, rd2, rd3, 8'(($urandom)), wacc);
            read_burst(ra, racc);
            drain();
        end

        // Command while busy is dropped and flagged; the in-flight read is untouched.
        check("overrun_clear_before", 64'(cmd_overrun), 64'(0));
        read_burst(12'h004, racc);
        repeat (4) tick();
        br_cmd     = 1'b1;
        br_addr    = 12'h004;
        br_wr_data = {$urandom, $urandom};
        br_cmd_en  = 1'b1;
        tick();
        br_cmd_en  = 1'b0;
        check("overrun_set", 64'(cmd_overrun), 64'(1));
        repeat (CI - 7) tick();
        check("busy_after_overrun", 64'(busy), 64'(1));
        tick();
        check("idle_after_overrun", 64'(busy), 64'(0));
        read_burst(12'h004, racc2);
        check("reaccept_cycle", 64'(racc2), 64'(racc + CI));
        drain();
        check("overrun_sticky", 64'(cmd_overrun), 64'(1));

        // Reset during the second read beat.
        read_burst(12'h004, racc);
        repeat (L + 1) tick();
        check("mid_read_valid", 64'(br_rd_data_valid), 64'(1));
        rst = 1'b1;
        tick();
        check("rst_drop_valid", 64'(br_rd_data_valid), 64'(0));
        check("rst_drop_data",  br_rd_data,            64'h0);
        sb_q.delete();
        tick();
        check_reset_state("rst3");
        rst = 1'b0;
        wait_ready();
        read_burst(12'h004, racc);
        drain();
        read_burst(12'h100, racc);
        drain();

        repeat (4) tick();
        check("sb_final_empty", 64'(sb_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_ram.md
BURST_RAM -- requirements
Module: burst_ram

Interface
REQ-001 SHALL have parameter DEPTH_BITWIDTH, default 12, giving 2^DEPTH_BITWIDTH words of 64 bits (32 KB).
REQ-002 SHALL have parameter READ_LATENCY, default 8: cycles from command-accept edge to first read beat, legal range 2..15.
REQ-003 SHALL have parameter COMMAND_INTERVAL, default 14: minimum edges between two accepted commands, at least READ_LATENCY+4.
REQ-004 SHALL have parameter INIT_CYCLES, default 16: calibration delay after reset.
REQ-005 clk  input  1  clock; all logic on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 br_cmd  input  1  0 = read, 1 = write.
REQ-008 br_cmd_en  input  1  command and address valid this cycle.
REQ-009 br_addr  input  DEPTH_BITWIDTH  64-bit word address of the first beat.
REQ-010 br_wr_data  input  64  write beat data.
REQ-011 br_data_mask  input  8  accepted and ignored; all bytes are always written.
REQ-012 br_rd_data  output  64  read beat data.
REQ-013 br_rd_data_valid  output  1  br_rd_data holds a valid beat.
REQ-014 busy  output  1  a command presented now will not be accepted.
REQ-015 init_calib  output  1  calibration done; commands may be accepted.
REQ-016 cmd_overrun  output  1  sticky: a command arrived while busy was high.

Function
REQ-017 Every burst SHALL be 4 beats at addresses A, A+1, A+2, A+3, where A = br_addr, wrapping modulo 2^DEPTH_BITWIDTH.
REQ-018 A command SHALL be accepted at edge E0 only when br_cmd_en=1 and busy=0.
REQ-019 busy SHALL equal !init_calib OR (interval counter != 0); an accepted command loads the counter to COMMAND_INTERVAL-1 at E0.
REQ-020 Write: br_wr_data sampled at E0, E0+1, E0+2, E0+3 SHALL be stored to A, A+1, A+2, A+3; br_cmd_en is not required after E0.
REQ-021 Read: br_rd_data_valid SHALL be high for exactly 4 consecutive cycles, following edges E0+READ_LATENCY through E0+READ_LATENCY+3, carrying words A..A+3 in order.
REQ-022 br_rd_data SHALL be 0 whenever br_rd_data_valid=0.
REQ-023 A read of A+k issued after a completed write burst to A+k SHALL return the newly written data.
REQ-024 br_cmd_en=1 while busy=1 SHALL be ignored and SHALL set cmd_overrun until reset; the in-flight burst is unaffected.
REQ-025 The FSM SHALL have states INIT, IDLE, WRITE (beats 1..3), READ_WAIT, READ_BURST and RECOVER (counter draining).
REQ-026 Transitions: INIT->IDLE after INIT_CYCLES; IDLE->WRITE or READ_WAIT on accept; WRITE->RECOVER after beat 3; READ_WAIT->READ_BURST at latency; READ_BURST->RECOVER after beat 3; RECOVER->IDLE when counter=0.
REQ-027 init_calib SHALL rise INIT_CYCLES edges after the last edge with rst=1 and stay high until the next reset.

Reset
REQ-028 rst=1 SHALL drive br_rd_data=0, br_rd_data_valid=0, cmd_overrun=0, init_calib=0, busy=1 and state INIT at the next edge.
REQ-029 Reset mid-burst SHALL abandon the burst; array contents are not cleared, and beats already written remain.

Structure
REQ-030 Package burst_ram_pkg SHALL hold BURST_BEATS=4, the state enum, and the default latency and interval constants.
REQ-031 Storage SHALL be one sub-module, burst_ram_array: 64-bit simple dual-port block RAM with one write and one registered read port.

Verification
REQ-032 Reset, then count cycles -> init_calib rises exactly 16 edges after rst falls; busy=1 until then; a cmd_en issued before that sets cmd_overrun.
REQ-033 Write at addr 0x004 with beats 0x1111..1111, 0x2222..2222, 0x3333..3333, 0x4444..4444; read 0x004 at E0+14 -> valid at E+8..E+11 with the same four words in order.
REQ-034 Write at addr 0xFFE with beats 1,2,3,4 -> read 0xFFE returns 1,2,3,4; read 0x000 returns 3,4 as its first two beats (wrap).
REQ-035 Second cmd_en 5 cycles after an accepted read -> ignored, cmd_overrun=1, first burst still delivers 4 beats, next command accepted at E0+14.
REQ-036 rst asserted at the 2nd beat of a read -> valid drops at the next edge; after init, a re-read returns correct data.
REQ-037 Write with br_data_mask=0xFF and data 0xDEADBEEF_CAFEF00D -> a readback returns 0xDEADBEEF_CAFEF00D (mask ignored).
